// File: rtl/noc_flit_mux2.sv
// -----------------------------------------------------------------------------
// noc_flit_mux2
//   Two-input flit multiplexer for the NoC router datapath. One of two flit
//   channels (data, valid, virtual-channel id) is forwarded to a single
//   registered output port under a one-hot select vector. There is one clock
//   of latency and no combinational path from input to output. Flit type bits
//   (upper 2 bits of data) are carried untouched; packet framing belongs to
//   the sender.
//
// Parameters
//   DATA_W  flit width in bits (upper 2 bits = flit type, not interpreted)
//   VCH_W   virtual-channel id width
//   SEL_W   select vector width (router port count), >= 2
//
// Ports
//   clk                   rising-edge clock
//   rst_                  asynchronous active-low reset, clears all outputs
//   idata_0/ivalid_0/ivch_0  flit channel 0
//   idata_1/ivalid_1/ivch_1  flit channel 1
//   sel                   one-hot select: bit0 -> channel 0, bit1 -> channel 1
//   odata/ovalid/ovch     registered selected flit
//   oerr                  (NOC_FLIT_MUX_SELCHK_EN only) registered illegal-select flag
//
// Build option
//   NOC_FLIT_MUX_SELCHK_EN  when defined, an illegal select (sel[1:0]=11 or any
//                           upper select bit set) drops the flit and raises oerr
//                           for one cycle. When undefined, sel[1:0]=11 resolves
//                           to channel 0 and the upper select bits are ignored.
// -----------------------------------------------------------------------------
module noc_flit_mux2 #(
  parameter int DATA_W = 64,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata_0,
  input  logic              ivalid_0,
  input  logic [VCH_W-1:0]  ivch_0,
  input  logic [DATA_W-1:0] idata_1,
  input  logic              ivalid_1,
  input  logic [VCH_W-1:0]  ivch_1,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] odata,
  output logic              ovalid,
  output logic [VCH_W-1:0]  ovch
`ifdef NOC_FLIT_MUX_SELCHK_EN
  ,
  output logic              oerr
`endif
);

  logic [DATA_W-1:0] data_p1_d;
  logic [DATA_W-1:0] data_p1_q;
  logic              vld_p1_d;
  logic              vld_p1_q;
  logic [VCH_W-1:0]  vch_p1_d;
  logic [VCH_W-1:0]  vch_p1_q;

`ifdef NOC_FLIT_MUX_SELCHK_EN
  logic [SEL_W-1:0]  sel_hi;
  logic              sel_illegal;
  logic              err_p1_d;
  logic              err_p1_q;

  // Shift rather than slice so SEL_W=2 (no upper bits) stays legal.
  assign sel_hi      = sel >> 2;
  assign sel_illegal = (sel[1:0] == 2'b11) || (|sel_hi);
`else
  logic [SEL_W-1:0]  sel_unused;

  // Upper select bits have no meaning without the select checker.
  assign sel_unused = sel >> 2;
`endif

  // ---- stage p0 -> p1: select the channel to capture ----
  always_comb begin
    data_p1_d = '0;
    vld_p1_d  = 1'b0;
    vch_p1_d  = '0;
`ifdef NOC_FLIT_MUX_SELCHK_EN
    err_p1_d  = sel_illegal;
    if (!sel_illegal) begin
      if (sel[0]) begin
        data_p1_d = idata_0;
        vld_p1_d  = ivalid_0;
        vch_p1_d  = ivch_0;
      end else if (sel[1]) begin
        data_p1_d = idata_1;
        vld_p1_d  = ivalid_1;
        vch_p1_d  = ivch_1;
      end
    end
`else
    // Channel 0 has fixed priority when both select bits are set.
    if (sel[0]) begin
      data_p1_d = idata_0;
      vld_p1_d  = ivalid_0;
      vch_p1_d  = ivch_0;
    end else if (sel[1]) begin
      data_p1_d = idata_1;
      vld_p1_d  = ivalid_1;
      vch_p1_d  = ivch_1;
    end
`endif
  end

  // ---- stage p1: output register ----
  // Data and vch are reset too: the outputs must read zero during reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      vch_p1_q  <= '0;
    end else begin
      data_p1_q <= data_p1_d;
      vld_p1_q  <= vld_p1_d;
      vch_p1_q  <= vch_p1_d;
    end
  end

`ifdef NOC_FLIT_MUX_SELCHK_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_p1_q <= 1'b0;
    end else begin
      err_p1_q <= err_p1_d;
    end
  end

  assign oerr = err_p1_q;
`endif

  assign odata  = data_p1_q;
  assign ovalid = vld_p1_q;
  assign ovch   = vch_p1_q;

endmodule

// File: tb/tb_noc_flit_mux2.sv
// -----------------------------------------------------------------------------
// tb_noc_flit_mux2
//   Self-checking bench for noc_flit_mux2. A behavioural model derives the
//   expected registered flit from the select rules each rising edge; a
//   compare process checks the DUT against it on every falling edge. Directed
//   scenarios add hand-computed literal checks. Honours NOC_FLIT_MUX_SELCHK_EN.
// -----------------------------------------------------------------------------
module tb_noc_flit_mux2;

  localparam int DATA_W = 64;
  localparam int VCH_W  = 2;
  localparam int SEL_W  = 5;

  logic              clk = 1'b0;
  logic              rst_;
  logic [DATA_W-1:0] idata_0;
  logic              ivalid_0;
  logic [VCH_W-1:0]  ivch_0;
  logic [DATA_W-1:0] idata_1;
  logic              ivalid_1;
  logic [VCH_W-1:0]  ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;
`ifdef NOC_FLIT_MUX_SELCHK_EN
  logic              oerr;
`endif

  always #5 clk = ~clk;

  noc_flit_mux2 #(
    .DATA_W (DATA_W),
    .VCH_W  (VCH_W),
    .SEL_W  (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .ivch_0   (ivch_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .ivch_1   (ivch_1),
    .sel      (sel),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch)
`ifdef NOC_FLIT_MUX_SELCHK_EN
    ,
    .oerr     (oerr)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [VCH_W-1:0]  vch;
    logic              err;
  } flit_t;

  flit_t exp_q = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Select rules written directly from the behaviour table.
  function automatic flit_t rule(input logic [SEL_W-1:0] s,
                                 input logic [DATA_W-1:0] d0, input logic v0, input logic [VCH_W-1:0] c0,
                                 input logic [DATA_W-1:0] d1, input logic v1, input logic [VCH_W-1:0] c1);
    flit_t r;
    r = '0;
`ifdef NOC_FLIT_MUX_SELCHK_EN
    if (s[1:0] == 2'b11 || (s >> 2) != 0) begin
      r.err = 1'b1;
      return r;
    end
`endif
    case (s[1:0])
      2'b01, 2'b11: begin r.data = d0; r.valid = v0; r.vch = c0; end
      2'b10:        begin r.data = d1; r.valid = v1; r.vch = c1; end
      default:      r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_) begin
    if (!rst_) exp_q <= '0;
    else       exp_q <= rule(sel, idata_0, ivalid_0, ivch_0, idata_1, ivalid_1, ivch_1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_odata",  odata,  exp_q.data);
      check("model_ovalid", {63'd0, ovalid}, {63'd0, exp_q.valid});
      check("model_ovch",   {62'd0, ovch},   {62'd0, exp_q.vch});
`ifdef NOC_FLIT_MUX_SELCHK_EN
      check("model_oerr",   {63'd0, oerr},   {63'd0, exp_q.err});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  localparam logic [63:0] PAT_A = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] PAT_B = 64'h5555_AAAA_5555_AAAA;
  localparam logic [63:0] HEAD1 = 64'h4000_0000_0000_0004;
  localparam logic [63:0] TAIL1 = 64'hC000_0000_0000_0001;

  initial begin
    // Reset with both inputs active.
    rst_ = 1'b1;
    sel = 5'b00001;
    idata_0 = 64'h1111_2222_3333_4444; ivalid_0 = 1'b1; ivch_0 = 2'd2;
    idata_1 = 64'h9999_8888_7777_6666; ivalid_1 = 1'b1; ivch_1 = 2'd3;
    #1 rst_ = 1'b0;
    #1;
    check("rst_async_odata",  odata, 64'd0);
    check("rst_async_ovalid", {63'd0, ovalid}, 64'd0);
    check("rst_async_ovch",   {62'd0, ovch}, 64'd0);
    chk_en = 1'b1;
    repeat (3) step();
    check("rst_held_odata", odata, 64'd0);
    rst_ = 1'b1;
    #1;
    check("rel_before_edge_ovalid", {63'd0, ovalid}, 64'd0);
    step();
    check("rel_first_odata", odata, 64'h1111_2222_3333_4444);
    check("rel_first_ovch",  {62'd0, ovch}, 64'd2);

    // Port 1 packet stream.
    sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd1; ivalid_0 = 1'b0; ivch_0 = 2'd0;
    idata_1 = HEAD1; idata_0 = {$urandom, $urandom};
    step();
    check("p1_head_odata",  odata, HEAD1);
    check("p1_head_ovalid", {63'd0, ovalid}, 64'd1);
    check("p1_head_ovch",   {62'd0, ovch}, 64'd1);
    for (int i = 0; i < 20; i++) begin
      idata_1 = {2'b10, 62'h800 << i};
      idata_0 = {$urandom, $urandom};
      step();
    end
    check("p1_last_body", odata, {2'b10, 62'h800 << 19});
    idata_1 = TAIL1;
    step();
    check("p1_tail_odata", odata, TAIL1);

    // Port 0 with random traffic on both ports.
    for (int i = 0; i < 30; i++) begin
      sel = 5'b00001;
      idata_0 = {$urandom, $urandom}; ivalid_0 = 1'($urandom); ivch_0 = 2'($urandom);
      idata_1 = {$urandom, $urandom}; ivalid_1 = 1'($urandom); ivch_1 = 2'($urandom);
      step();
    end

    // Packets separated by idle gaps.
    for (int p = 0; p < 10; p++) begin
      for (int f = 0; f < 22; f++) begin
        sel = 5'b00001; ivalid_0 = 1'b1; ivch_0 = 2'(p);
        idata_0 = {32'(p), 32'(f)};
        step();
      end
      for (int g = 0; g < 7; g++) begin
        ivalid_0 = 1'b0;
        idata_0 = {$urandom, $urandom};
        step();
      end
    end
    idata_0 = 64'h0000_0000_0000_1D1E; ivalid_0 = 1'b0;
    step();
    check("gap_idle_payload", odata, 64'h0000_0000_0000_1D1E);
    check("gap_ovalid",       {63'd0, ovalid}, 64'd0);

    // Idle select and priority.
    idata_0 = PAT_A; ivalid_0 = 1'b1; ivch_0 = 2'd2;
    idata_1 = PAT_B; ivalid_1 = 1'b1; ivch_1 = 2'd1;
    sel = 5'b00000;
    step();
    check("idle_odata",  odata, 64'd0);
    check("idle_ovalid", {63'd0, ovalid}, 64'd0);
    sel = 5'b00011;
    step();
`ifdef NOC_FLIT_MUX_SELCHK_EN
    check("prio_odata",  odata, 64'd0);
    check("prio_ovalid", {63'd0, ovalid}, 64'd0);
    check("prio_oerr",   {63'd0, oerr}, 64'd1);
`else
    check("prio_odata",  odata, PAT_A);
    check("prio_ovalid", {63'd0, ovalid}, 64'd1);
    check("prio_ovch",   {62'd0, ovch}, 64'd2);
`endif
    sel = 5'b00110;
    step();
    sel = 5'b10001;
    step();
    sel = 5'b00010;
    step();

    // Per-cycle switching with stability checks late in the cycle.
    for (int i = 0; i < 20; i++) begin
      sel = (i % 2 == 0) ? 5'b00001 : 5'b00010;
      step();
      check("sw_odata", odata, (i % 2 == 0) ? PAT_A : PAT_B);
      #6;
      check("sw_stable", odata, (i % 2 == 0) ? PAT_A : PAT_B);
    end

    // Reset asserted mid-packet.
    sel = 5'b00010; ivalid_1 = 1'b1; ivch_1 = 2'd3;
    for (int i = 0; i < 5; i++) begin
      idata_1 = 64'h0BAD_0000_0000_0000 | 64'(i);
      step();
    end
    rst_ = 1'b0;
    #1;
    check("midrst_odata",  odata, 64'd0);
    check("midrst_ovalid", {63'd0, ovalid}, 64'd0);
    repeat (2) step();
    rst_ = 1'b1;
    idata_1 = 64'h0BAD_0000_0000_0077;
    step();
    check("post_rst_odata", odata, 64'h0BAD_0000_0000_0077);
    repeat (3) step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
